flash_qspi_arbiter: RTL

// Shares one QSPI flash read device between two streaming requesters (e.g. two flash buffers).

---
 rtl/flash_qspi_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/flash_qspi_arbiter.sv
// Two-requester arbiter in front of one QSPI flash read device, keeping a resume address per stream.
// Define FLASH_QSPI_ARBITER_PRIORITY_EN to give requester 0 fixed priority instead of round-robin bursts.
module flash_qspi_arbiter #(
    parameter int MAX_BURST_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_enable,
    input  logic [47:0] req_address,
    input  logic [1:0]  req_changeAddress,
    input  logic [1:0]  req_requestData,
    output logic [31:0] req_readData,
    output logic [1:0]  req_readDataValid,
    output logic [1:0]  req_granted,
    output logic        qspi_enable,
    output logic [23:0] qspi_address,
    output logic        qspi_changeAddress,
    output logic        qspi_requestData,
    input  logic [31:0] qspi_readData,
    input  logic        qspi_readDataValid
);
    typedef enum logic [1:0] {IDLE, SWITCH, STREAM} state_t;

    state_t      state, state_d;
    logic        owner, owner_d;
    logic        last_owner, last_owner_d;
    logic [8:0]  burst, burst_d;
    logic [23:0] resume [2];
    logic [23:0] resume_d [2];
    logic [1:0]  want;
    logic        deliver;
    logic        burst_end;
    logic        pick;
    logic        preempt;

    assign want      = req_enable & req_requestData;
    assign deliver   = (state == STREAM) && qspi_readDataValid;
    assign burst_end = ((burst + 9'd1) == 9'(MAX_BURST_WORDS));

`ifdef FLASH_QSPI_ARBITER_PRIORITY_EN
    assign pick    = ~want[0];
    assign preempt = deliver && owner && want[0];
`else
    assign pick    = (want == 2'b11) ? ~last_owner : want[1];
    assign preempt = deliver && burst_end && want[~owner];
`endif

    // A new stream start always overrides the post-delivery increment.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            resume_d[i] = resume[i];
            if (req_changeAddress[i]) begin
                resume_d[i] = req_address[24*i +: 24] & 24'hFFFFFC;
            end else if (deliver && (owner == 1'(i))) begin
                resume_d[i] = resume[i] + 24'd4;
            end
        end
    end

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        burst_d      = burst;
        case (state)
            IDLE: begin
                if (|want) begin
                    owner_d = pick;
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                burst_d = '0;
                if (!req_changeAddress[owner]) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (deliver) begin
                    burst_d = burst_end ? burst : burst + 9'd1;
                end
                if (req_changeAddress[owner]) begin
                    state_d = SWITCH;
                end else if (!want[owner]) begin
                    state_d      = IDLE;
                    last_owner_d = owner;
                end else if (preempt) begin
                    owner_d      = ~owner;
                    last_owner_d = owner;
                    state_d      = SWITCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_granted       = '0;
        req_readDataValid = '0;
        qspi_requestData  = 1'b0;
        if (state != IDLE) begin
            req_granted[owner] = 1'b1;
        end
        if (state == STREAM) begin
            qspi_requestData         = want[owner];
            req_readDataValid[owner] = qspi_readDataValid;
        end
    end

    // Gated by reset so every output reads zero while rst is held low.
    assign qspi_enable  = rst & (|req_enable);
    assign req_readData = rst ? qspi_readData : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            owner              <= 1'b0;
            last_owner         <= 1'b1;
            burst              <= '0;
            resume[0]          <= '0;
            resume[1]          <= '0;
            qspi_address       <= '0;
            qspi_changeAddress <= 1'b0;
        end else begin
            state              <= state_d;
            owner              <= owner_d;
            last_owner         <= last_owner_d;
            burst              <= burst_d;
            resume[0]          <= resume_d[0];
            resume[1]          <= resume_d[1];
            qspi_changeAddress <= (state_d == SWITCH);
            qspi_address       <= (state_d == SWITCH) ? resume_d[owner_d] : '0;
        end
    end
endmodule
